// File: rtl/hs_pkg.sv
// rtl/hs_pkg.sv - shared types and limits for the 4-phase round-robin arbiter
//
// Purpose: FSM state encoding and the largest supported requester count,
// shared by hs_rr_arbiter and its winner-selection helper.
// Ports: none (package).

package hs_pkg;

  localparam int HS_MAX_N = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,  // no owner, arbitrating
    FWD  = 2'd1,  // request forwarded to target, waiting for trg_ack_i
    ACK  = 2'd2,  // owner acknowledged, waiting for its request to fall
    RTZ  = 2'd3   // target request dropped, waiting for trg_ack_i to fall
  } t_hs_arb_state;

endpackage

// File: rtl/hs_rr_pick.sv
// rtl/hs_rr_pick.sv - combinational round-robin winner selection
//
// Purpose: picks the first set request bit at or above ptr, wrapping modulo N.
// Ports:
//   req    [N-1:0]  request vector
//   ptr    [IW-1:0] search start position
//   onehot [N-1:0]  one-hot winner (all-zero when no request)
//   idx    [IW-1:0] binary winner index (0 when no request)
//   valid           at least one request present

module hs_rr_pick
  import hs_pkg::*;
#(
  parameter int N  = 4,
  parameter int IW = $clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  onehot,
  output logic [IW-1:0] idx,
  output logic          valid
);

  always_comb begin
    int j;
    onehot = '0;
    idx    = '0;
    valid  = 1'b0;
    j      = 0;
    // Walk positions ptr, ptr+1, ... and keep only the first hit.
    for (int k = 0; k < N; k++) begin
      j = (int'(ptr) + k) % N;
      if (!valid && req[j]) begin
        valid     = 1'b1;
        onehot[j] = 1'b1;
        idx       = IW'(j);
      end
    end
  end

endmodule

// File: rtl/hs_rr_arbiter.sv
// rtl/hs_rr_arbiter.sv - round-robin arbiter bridging N 4-phase requesters to one target
//
// Purpose: grants one requester at a time access to a shared 4-phase target,
// relaying the handshake and flagging protocol violations.
// Ports:
//   clk, rst             clock, synchronous active-high reset
//   req_i     [N-1:0]    per-requester 4-phase request
//   ack_o     [N-1:0]    per-requester 4-phase acknowledge (registered)
//   trg_req_o            request to the shared target (registered)
//   trg_ack_i            acknowledge from the shared target
//   gnt_o     [N-1:0]    one-hot current owner, zero when idle (registered)
//   gnt_idx_o [IW-1:0]   binary owner index, zero when idle (registered)
//   proto_err_o          one-cycle pulse on a protocol violation (registered)

module hs_rr_arbiter
  import hs_pkg::*;
#(
  parameter int N  = 4,
  parameter int IW = $clog2(N)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [N-1:0]  req_i,
  output logic [N-1:0]  ack_o,
  output logic          trg_req_o,
  input  logic          trg_ack_i,
  output logic [N-1:0]  gnt_o,
  output logic [IW-1:0] gnt_idx_o,
  output logic          proto_err_o
);

  t_hs_arb_state state_q, state_d;
  logic [IW-1:0] ptr_q, ptr_d;
  logic [IW-1:0] idx_q, idx_d;
  logic [N-1:0]  gnt_q, gnt_d;
  logic [N-1:0]  ack_q, ack_d;
  logic [N-1:0]  req_prev_q, req_prev_d;
  logic          trg_req_q, trg_req_d;
  logic          trg_ack_prev_q, trg_ack_prev_d;
  logic          err_q, err_d;

  logic [N-1:0]  pick_onehot;
  logic [IW-1:0] pick_idx;
  logic          pick_valid;
  logic          req_g;
  logic          req_g_prev;

  hs_rr_pick #(
    .N  (N),
    .IW (IW)
  ) u_pick (
    .req    (req_i),
    .ptr    (ptr_q),
    .onehot (pick_onehot),
    .idx    (pick_idx),
    .valid  (pick_valid)
  );

  // Owner's request now and one cycle ago; previous-cycle samples let the
  // violation checks fire on the falling edge only, giving a single pulse.
  assign req_g      = |(req_i & gnt_q);
  assign req_g_prev = |(req_prev_q & gnt_q);

  always_comb begin
    state_d        = state_q;
    ptr_d          = ptr_q;
    idx_d          = idx_q;
    gnt_d          = gnt_q;
    ack_d          = ack_q;
    trg_req_d      = trg_req_q;
    err_d          = 1'b0;
    req_prev_d     = req_i;
    trg_ack_prev_d = trg_ack_i;
    case (state_q)
      IDLE: begin
        // A target ack with nothing outstanding blocks arbitration this cycle.
        if (trg_ack_i) begin
          err_d = 1'b1;
        end else if (pick_valid) begin
          gnt_d     = pick_onehot;
          idx_d     = pick_idx;
          trg_req_d = 1'b1;
          state_d   = FWD;
        end
      end
      FWD: begin
        // Withdrawal is reported but the target transaction still runs to completion.
        if (req_g_prev && !req_g) begin
          err_d = 1'b1;
        end
        if (trg_ack_i) begin
          ack_d   = gnt_q;
          state_d = ACK;
        end
      end
      ACK: begin
        if (trg_ack_prev_q && !trg_ack_i) begin
          err_d = 1'b1;
        end else if (!req_g) begin
          trg_req_d = 1'b0;
          state_d   = RTZ;
        end
      end
      RTZ: begin
        if (!trg_ack_i) begin
          ack_d   = '0;
          gnt_d   = '0;
          idx_d   = '0;
          ptr_d   = (idx_q == IW'(N - 1)) ? '0 : idx_q + IW'(1);
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= IDLE;
      ptr_q          <= '0;
      idx_q          <= '0;
      gnt_q          <= '0;
      ack_q          <= '0;
      req_prev_q     <= '0;
      trg_req_q      <= 1'b0;
      trg_ack_prev_q <= 1'b0;
      err_q          <= 1'b0;
    end else begin
      state_q        <= state_d;
      ptr_q          <= ptr_d;
      idx_q          <= idx_d;
      gnt_q          <= gnt_d;
      ack_q          <= ack_d;
      req_prev_q     <= req_prev_d;
      trg_req_q      <= trg_req_d;
      trg_ack_prev_q <= trg_ack_prev_d;
      err_q          <= err_d;
    end
  end

  assign ack_o       = ack_q;
  assign trg_req_o   = trg_req_q;
  assign gnt_o       = gnt_q;
  assign gnt_idx_o   = idx_q;
  assign proto_err_o = err_q;

endmodule

// File: tb/tb_hs_rr_arbiter.sv
// tb/tb_hs_rr_arbiter.sv - scoreboard bench for hs_rr_arbiter

module tb_hs_rr_arbiter;

  localparam int N  = 4;
  localparam int IW = $clog2(N);

  localparam int M_NORMAL   = 0;
  localparam int M_WITHDRAW = 1;
  localparam int M_SPUR     = 2;
  localparam int M_RESET    = 3;
  localparam int M_ACKDROP  = 4;

  typedef struct {
    int idx;
    int cyc;
  } t_exp;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [N-1:0]  req_i = '0;
  logic          trg_ack_i = 1'b0;
  logic [N-1:0]  ack_o;
  logic          trg_req_o;
  logic [N-1:0]  gnt_o;
  logic [IW-1:0] gnt_idx_o;
  logic          proto_err_o;

  int   cyc = 0;
  int   n_chk = 0;
  int   n_fail = 0;
  int   model_ptr = 0;
  bit   mon_en = 1'b0;
  t_exp exp_gnt[$];
  int   exp_err[$];
  logic [N-1:0] prev_gnt = '0;

  hs_rr_arbiter #(.N(N), .IW(IW)) dut (
    .clk         (clk),
    .rst         (rst),
    .req_i       (req_i),
    .ack_o       (ack_o),
    .trg_req_o   (trg_req_o),
    .trg_ack_i   (trg_ack_i),
    .gnt_o       (gnt_o),
    .gnt_idx_o   (gnt_idx_o),
    .proto_err_o (proto_err_o)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference rule: first requester at or after the pointer, wrapping around.
  function automatic int model_pick(input logic [N-1:0] m);
    for (int k = 0; k < N; k++) begin
      if (m[(model_ptr + k) % N]) return (model_ptr + k) % N;
    end
    return -1;
  endfunction

  task automatic check_all_zero(input string tag);
    check({tag, "_ack"}, int'(ack_o), 0);
    check({tag, "_trg_req"}, int'(trg_req_o), 0);
    check({tag, "_gnt"}, int'(gnt_o), 0);
    check({tag, "_gnt_idx"}, int'(gnt_idx_o), 0);
    check({tag, "_err"}, int'(proto_err_o), 0);
  endtask

  task automatic apply_reset();
    rst       = 1'b1;
    req_i     = '0;
    trg_ack_i = 1'b0;
    @(negedge clk);
    @(negedge clk);
    exp_gnt.delete();
    exp_err.delete();
    rst       = 1'b0;
    model_ptr = 0;
  endtask

  // One arbitration round: apply mask at a negedge while the DUT is idle,
  // then play requester and target until the owner's ack returns to zero.
  task automatic do_round(input logic [N-1:0] mask, input int mode);
    int   g, tdly, rdly, budget, k;
    bit   saw_ack, withdrawn;
    t_exp e;
    g     = model_pick(mask);
    req_i = mask;
    if (mode == M_SPUR) begin
      trg_ack_i = 1'b1;
      exp_err.push_back(cyc + 1);
      @(negedge clk);
      trg_ack_i = 1'b0;
    end
    if (g < 0) begin
      repeat ($urandom_range(2, 4)) @(negedge clk);
      return;
    end
    e.idx = g;
    e.cyc = cyc + 1;
    exp_gnt.push_back(e);
    tdly      = $urandom_range(0, 3);
    rdly      = $urandom_range(0, 3);
    saw_ack   = 1'b0;
    withdrawn = 1'b0;
    budget    = 0;
    forever begin
      @(negedge clk);
      budget++;
      if (budget > 100) begin
        n_chk++;
        n_fail++;
        $display("FAIL round_timeout: requester %0d handshake incomplete after %0d cycles", g, budget - 1);
        apply_reset();
        return;
      end
      if (saw_ack && !ack_o[g]) break;
      if (trg_req_o != trg_ack_i) begin
        if (tdly == 0) begin
          trg_ack_i = trg_req_o;
          tdly      = $urandom_range(0, 3);
        end else begin
          tdly--;
        end
      end
      if (mode == M_WITHDRAW && !withdrawn && gnt_o[g]) begin
        req_i[g]  = 1'b0;
        withdrawn = 1'b1;
        exp_err.push_back(cyc + 1);
      end else if (ack_o[g] && req_i[g]) begin
        if (rdly == 0) req_i[g] = 1'b0;
        else rdly--;
      end
      k = $urandom_range(0, N - 1);
      if (k != g && $urandom_range(0, 3) == 0) req_i[k] = ~req_i[k];
      if (ack_o[g] && !saw_ack) begin
        saw_ack = 1'b1;
        if (mode == M_RESET) begin
          rst = 1'b1;
          @(negedge clk);
          check_all_zero("midop_reset");
          rst       = 1'b0;
          trg_ack_i = 1'b0;
          req_i     = '0;
          model_ptr = 0;
          return;
        end
        if (mode == M_ACKDROP) begin
          trg_ack_i = 1'b0;
          tdly      = $urandom_range(1, 3);
          exp_err.push_back(cyc + 1);
        end
      end
    end
    model_ptr = (g + 1) % N;
  endtask

  always @(negedge clk) begin
    t_exp e;
    int   ec;
    if (mon_en) begin
      check("gnt_onehot0", int'($onehot0(gnt_o)), 1);
      check("ack_onehot0", int'($onehot0(ack_o)), 1);
      check("ack_only_owner", int'(ack_o & ~gnt_o), 0);
      if (gnt_o == '0) check("idx_zero_idle", int'(gnt_idx_o), 0);
      if (gnt_o != '0 && prev_gnt == '0) begin
        if (exp_gnt.size() == 0) begin
          n_chk++;
          n_fail++;
          $display("FAIL unexpected_grant: gnt_o=%b with no grant expected (cycle %0d)", gnt_o, cyc);
        end else begin
          e = exp_gnt.pop_front();
          check("grant_idx", int'(gnt_idx_o), e.idx);
          check("grant_onehot", int'(gnt_o), 1 << e.idx);
          check("grant_cycle", cyc, e.cyc);
          check("trg_req_with_grant", int'(trg_req_o), 1);
          check("ack_clear_at_grant", int'(ack_o), 0);
        end
      end
      if (proto_err_o) begin
        if (exp_err.size() == 0) begin
          n_chk++;
          n_fail++;
          $display("FAIL unexpected_proto_err: pulse with none expected (cycle %0d)", cyc);
        end else begin
          ec = exp_err.pop_front();
          check("proto_err_cycle", cyc, ec);
        end
      end
    end
    prev_gnt = gnt_o;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached (cycle %0d)", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [N-1:0] m;
    int           r, mode;
    repeat (3) @(negedge clk);
    check_all_zero("reset");
    mon_en = 1'b1;
    rst    = 1'b0;

    // Single requester, then reset in ACK and a fresh request from requester 2.
    do_round(4'b0001, M_NORMAL);
    do_round(4'b0001, M_RESET);
    do_round(4'b0100, M_NORMAL);
    // Pointer now 3: wrap case.
    do_round(4'b1001, M_NORMAL);
    do_round(4'b1001, M_NORMAL);
    // Spurious target ack while idle, without and with pending requests.
    do_round(4'b0000, M_SPUR);
    do_round(4'b0110, M_SPUR);

    // Full contention from pointer 0: expect 0,1,2,3,0.
    apply_reset();
    repeat (5) do_round(4'b1111, M_NORMAL);

    // Withdrawal of requester 2 in FWD, and target ack dropping in ACK.
    do_round(4'b0100, M_WITHDRAW);
    do_round(4'b1011, M_ACKDROP);

    for (int i = 0; i < 60; i++) begin
      m = N'($urandom_range(0, (1 << N) - 1));
      r = $urandom_range(0, 9);
      if (r <= 4) mode = M_NORMAL;
      else if (r <= 6) mode = M_WITHDRAW;
      else if (r == 7) mode = M_SPUR;
      else if (r == 8) mode = M_ACKDROP;
      else mode = M_RESET;
      do_round(m, mode);
    end

    req_i = '0;
    repeat (5) @(negedge clk);
    check("pending_grants", exp_gnt.size(), 0);
    check("pending_errors", exp_err.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
